// File: rtl/hs4_return_if.sv
// hs4_return_if: return-channel bundle (req_in/data_in/ack_out peripheral side, out_data/out_valid/out_ready/fifo_count/rx_state CPU side); slave=receiver, master=bench/environment
interface hs4_return_if #(parameter int DW = 4, parameter int CW = 3);
  logic          req_in;
  logic [DW-1:0] data_in;
  logic          ack_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic [1:0]    rx_state;
  modport master(output req_in, data_in, out_ready, input ack_out, out_data, out_valid, fifo_count, rx_state);
  modport slave(input req_in, data_in, out_ready, output ack_out, out_data, out_valid, fifo_count, rx_state);
endinterface

// File: rtl/hs4_return_receiver.sv
// hs4_return_receiver: 4-phase req/ack capture into a show-ahead FIFO with valid/ready output; ports clk, rst (sync active-low), bus (hs4_return_if.slave); RX_SYNC_EN adds a 2-flop req synchronizer
module hs4_return_receiver #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  hs4_return_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, ACK = 2'b01, STALL = 2'b10, BAD = 2'b11} state_t;
  state_t        state, state_nx;
  logic          req_s, push, pop, space;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
`ifdef RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) sync <= !rst ? 2'b00 : {sync[0], bus.req_in};
  assign req_s = sync[1];
`else
  assign req_s = bus.req_in;
`endif
  assign space = count < CW'(DEPTH);
  assign pop   = count != '0 && bus.out_ready;
  // IDLE and STALL share the same decision: push when space, else wait in STALL
  always_comb begin
    state_nx = IDLE;
    push     = 1'b0;
    state_nx = state == ACK ? (req_s ? ACK : IDLE) :
               (state == BAD || !req_s) ? IDLE : space ? ACK : STALL;
    push     = (state == IDLE || state == STALL) && req_s && space;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (rst && push) mem[wr_ptr] <= bus.data_in;
  assign bus.ack_out    = state == ACK;
  assign bus.out_valid  = count != '0;
  assign bus.out_data   = count != '0 ? mem[rd_ptr] : '0;
  assign bus.fifo_count = count;
  assign bus.rx_state   = state;
endmodule

// File: doc/hs4_return_receiver.md
Name: hs4_return_receiver

Overview:
- Receiving end of the peripheral-to-CPU return channel of the 4-phase send/ack handshake.
- The peripheral drives req_in and data_in. This block captures each word and answers with ack_out.
- Captured words are buffered in a small FIFO and presented to the CPU side over a valid/ready interface.
- Applies back-pressure: ack_out is withheld while the FIFO is full, so no word is ever dropped.

Parameters:
- DW, 4, data word width in bits.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- CW, 3, fifo_count width; must be at least clog2(DEPTH+1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_in  input  1  peripheral send strobe; data_in is valid while high.
- data_in  input  DW  peripheral data word.
- ack_out  output  1  4-phase acknowledge to peripheral.
- out_data  output  DW  head-of-FIFO word (show-ahead).
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  CPU consumes out_data when out_valid && out_ready.
- fifo_count  output  CW  number of words held.
- rx_state  output  2  current FSM state, for debug/observation.

Behaviour:
- Reset (rst==0 at a clk edge):
  - ack_out=0, fifo_count=0, out_valid=0, out_data=0, rx_state=IDLE.
  - FIFO pointers cleared; buffered data discarded.
  - Reset overrides every other event in the same cycle.
- req_s:
  - Equals req_in, or the synchronized copy when RX_SYNC_EN is defined.
  - data_in is always sampled directly; the peripheral holds it stable from req rise until ack seen.
- FSM states and encodings: IDLE=2'b00, ACK=2'b01, STALL=2'b10. Code 2'b11 is illegal and returns to IDLE next cycle with ack_out=0.
- IDLE:
  - req_s==1 and count<DEPTH: push data_in, ack_out<=1, go to ACK.
  - req_s==1 and count==DEPTH: go to STALL, ack_out stays 0.
  - Otherwise hold.
- STALL:
  - ack_out=0.
  - Once count<DEPTH (including a pop freeing space this cycle, evaluated on the registered count): push data_in, ack_out<=1, go to ACK.
  - If req_s drops while stalled (protocol violation): go to IDLE, no push.
- ACK:
  - req_s==0: ack_out<=0, go to IDLE.
  - req_s==1: hold with ack_out=1.
  - No second push occurs until req_s has been seen low. One req pulse yields exactly one word.
- Latency:
  - ack_out rises 1 clk after the edge where req_s is first seen high with space available.
  - The word is visible on out_data/out_valid in that same cycle.
- FIFO:
  - Show-ahead; out_data = mem[rd_ptr].
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop when empty is ignored. Push is never issued when full, per FSM rule.
- Reset mid-transfer:
  - If req_in is still high after reset releases, it is treated as a new transfer and captured again.
  - The peripheral is reset together with this block.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined:
  - req_in passes through a 2-flop synchronizer (both flops reset to 0) before the FSM.
  - req-rise to ack_out-rise latency becomes 3 clk.
  - req-fall to ack_out-fall latency becomes 3 clk.
- Undefined:
  - req_s = req_in directly.
  - Both latencies are 1 clk.
  - For use only when the peripheral shares clk.

Test Plan:
- Single transfer, macro off: req_in=1, data_in=4'h8 at cycle 0 → ack_out=1, out_valid=1, out_data=4'h8, fifo_count=1 at cycle 1. Drop req → ack_out=0 next cycle, rx_state=IDLE.
- Burst with out_ready=0: 4 transfers 1,2,3,4 → fifo_count=4. 5th req (data 5) → rx_state=STALL, ack_out stays 0. Pulse out_ready for 1 cycle → out_data was 1, then 5 accepted, ack_out=1. Drain order 2,3,4,5.
- Simultaneous push/pop: count=2, out_ready=1 during accepted push → fifo_count stays 2, FIFO order preserved across pointer wrap.
- Held req: req_in held high for 10 cycles → exactly one word pushed, ack_out high until req drops.
- Reset during ACK: rst=0 for 1 cycle → ack_out=0, fifo_count=0, out_valid=0. With req_in still high after release → one new word captured.
- RX_SYNC_EN defined: repeat the single-transfer test → ack_out rises 3 clk after req_in rises and falls 3 clk after req_in falls.
